// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the regfile block.
package regfile_pkg;

  // Sweep controller states: CLEAR zeroes storage one entry per cycle,
  // IDLE accepts normal traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/regfile_sweep.sv
// Post-reset clear sweep for regfile: walks ptr over every entry, issuing
// one zero-write per cycle, then settles in IDLE and raises ready.
module regfile_sweep
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_en_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          ready_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e          state_q;
  logic [AW-1:0]   ptr_q;

  // Sweep FSM and pointer; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (ptr_q == LAST) state_q <= IDLE;
          else               ptr_q   <= ptr_q + AW'(1);
        end
        IDLE:    state_q <= IDLE;
        default: state_q <= CLEAR;
      endcase
    end
  end

  // The zero-write happens on CLEAR edges not overridden by reset.
  assign clr_en_o   = (state_q == CLEAR) && !rst;
  assign clr_addr_o = ptr_q;
  assign ready_o    = (state_q == IDLE);

endmodule

// File: rtl/regfile.sv
// regfile: DEPTH x WIDTH register file, one write port, two combinational
// read ports. Storage is cleared by a sweep after reset so it may map to RAM.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle write data to
// a read port whose address matches the write address.
module regfile
  import regfile_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    wAddr,
  input  logic [WIDTH-1:0] bus,
  input  logic [AW-1:0]    aAddr,
  input  logic [AW-1:0]    bAddr,
  output logic [WIDTH-1:0] dA,
  output logic [WIDTH-1:0] dB,
  output logic             ready
);

  // One extra bit so the range check also works when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic          clr_en;
  logic [AW-1:0] clr_addr;

  logic             w_ok, a_ok, b_ok;
  logic             user_wr;
  logic             wr_en_d;
  logic [AW-1:0]    wr_addr_d;
  logic [WIDTH-1:0] wr_data_d;
  logic [AW-1:0]    a_idx, b_idx;
  logic [WIDTH-1:0] a_mem, b_mem;

  regfile_sweep #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sweep (
    .clk        (clk),
    .rst        (rst),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr),
    .ready_o    (ready)
  );

  assign w_ok = ({1'b0, wAddr} < DEPTH_W);
  assign a_ok = ({1'b0, aAddr} < DEPTH_W);
  assign b_ok = ({1'b0, bAddr} < DEPTH_W);

  // A user write request is only honoured once the sweep has finished.
  assign user_wr = ready && en && w_ok;

  // Write mux: sweep zero-writes in CLEAR, user writes in IDLE, none in reset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    wr_en_d   = 1'b0;
    wr_addr_d = wAddr;
    wr_data_d = bus;
    if (clr_en) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_addr;
      wr_data_d = '0;
    end else if (user_wr && !rst) begin
      wr_en_d   = 1'b1;
    end
  end

  // Storage array; contents are defined by the clear sweep, not by reset.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch so it can map onto RAM macros;
    // the sweep provides the zero initial contents instead.
    if (wr_en_d) mem_q[wr_addr_d] <= wr_data_d;
  end

  // Out-of-range read addresses are steered to entry 0 and masked below,
  // so the array is never indexed past its end.
  assign a_idx = a_ok ? aAddr : '0;
  assign b_idx = b_ok ? bAddr : '0;
  assign a_mem = (ready && a_ok) ? mem_q[a_idx] : '0;
  assign b_mem = (ready && b_ok) ? mem_q[b_idx] : '0;

`ifdef REGFILE_BYPASS_EN
  // Read ports with same-cycle forwarding of the pending write data.
  always_comb begin
    dA = a_mem;
    dB = b_mem;
    if (user_wr && (aAddr == wAddr)) dA = bus;
    if (user_wr && (bAddr == wAddr)) dB = bus;
  end
`else
  // Read ports return pre-write contents on a same-cycle address match.
  always_comb begin
    dA = a_mem;
    dB = b_mem;
  end
`endif

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: a DEPTH=8 instance for the main sequence and a
// DEPTH=6 instance for out-of-range addressing and writes during the sweep.
module tb_regfile;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=8 instance
  logic          rst8 = 1'b1, en8 = 1'b0, rdy8;
  logic [2:0]    wa8 = '0, aa8 = '0, ba8 = '0;
  logic [W-1:0]  bus8 = '0, da8, db8;

  // DEPTH=6 instance
  logic          rst6 = 1'b1, en6 = 1'b0, rdy6;
  logic [2:0]    wa6 = '0, aa6 = '0, ba6 = '0;
  logic [W-1:0]  bus6 = '0, da6, db6;

  int checks   = 0;
  int failures = 0;

  regfile #(.WIDTH(W), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .wAddr(wa8), .bus(bus8),
    .aAddr(aa8), .bAddr(ba8), .dA(da8), .dB(db8), .ready(rdy8)
  );

  regfile #(.WIDTH(W), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst6), .en(en6), .wAddr(wa6), .bus(bus6),
    .aAddr(aa6), .bAddr(ba6), .dA(da6), .dB(db6), .ready(rdy6)
  );

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_pre;

  initial begin
    #1;
    // ---------------- reset and first sweep (DEPTH=8) ----------------
    step();
    check("rst_ready", {15'b0, rdy8}, 16'h0);
    check("rst_dA", da8, 16'h0);
    check("rst_dB", db8, 16'h0);
    rst8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      aa8 = 3'(i);
      step();
      check($sformatf("sweep_ready_%0d", i), {15'b0, rdy8},
            (i == 8) ? 16'h1 : 16'h0);
      check($sformatf("sweep_dA_%0d", i), da8, 16'h0);
    end
    for (int i = 0; i < 8; i++) begin
      aa8 = 3'(i);
      #1;
      check($sformatf("post_sweep_dA_%0d", i), da8, 16'h0);
    end

    // ---------------- basic write / read ----------------
    en8 = 1'b1; wa8 = 3'd3; bus8 = 16'hF0F0;
    step();
    en8 = 1'b0; aa8 = 3'd3; ba8 = 3'd3;
    #1;
    check("wr3_dA", da8, 16'hF0F0);
    check("wr3_dB", db8, 16'hF0F0);

    bus8 = 16'hCCCC;
    repeat (3) step();
    check("en0_hold_dB", db8, 16'hF0F0);

    en8 = 1'b1; wa8 = 3'd5;
    step();
    en8 = 1'b0; aa8 = 3'd3; ba8 = 3'd5;
    #1;
    check("two_regs_dA", da8, 16'hF0F0);
    check("two_regs_dB", db8, 16'hCCCC);

    // ---------------- reset mid-sweep ----------------
    rst8 = 1'b1; step(); rst8 = 1'b0;
    repeat (4) step();            // entries 0..3 cleared, ptr now 4
    check("mid_sweep_ready", {15'b0, rdy8}, 16'h0);
    rst8 = 1'b1; step(); rst8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("resweep_ready_%0d", i), {15'b0, rdy8},
            (i == 8) ? 16'h1 : 16'h0);
    end
    aa8 = 3'd3; ba8 = 3'd5;
    #1;
    check("resweep_reg3", da8, 16'h0);
    check("resweep_reg5", db8, 16'h0);

    // ---------------- same-cycle read/write ----------------
    en8 = 1'b1; wa8 = 3'd2; bus8 = 16'hAAAA;
    step();
    bus8 = 16'h1234; aa8 = 3'd2; ba8 = 3'd2;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 16'h1234;
`else
    exp_pre = 16'hAAAA;
`endif
    check("same_cycle_dA_pre", da8, exp_pre);
    check("same_cycle_dB_pre", db8, exp_pre);
    step();
    en8 = 1'b0;
    #1;
    check("same_cycle_dA_post", da8, 16'h1234);
    check("same_cycle_dB_post", db8, 16'h1234);

    // ---------------- DEPTH=6: writes during CLEAR, out of range ----------
    step();                        // dut6 has been held in reset
    rst6 = 1'b0;
    en6 = 1'b1; wa6 = 3'd0; bus6 = 16'hBEEF;   // must be ignored in CLEAR
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("d6_ready_%0d", i), {15'b0, rdy6},
            (i == 6) ? 16'h1 : 16'h0);
    end
    en6 = 1'b0; aa6 = 3'd0;
    #1;
    check("d6_clear_write_dropped", da6, 16'h0);

    en6 = 1'b1; wa6 = 3'd5; bus6 = 16'h5555;
    step();
    en6 = 1'b1; wa6 = 3'd7; bus6 = 16'hFFFF;
    step();
    wa6 = 3'd6;
    step();
    en6 = 1'b0;
    aa6 = 3'd7; ba6 = 3'd6;
    #1;
    check("d6_oob_read7", da6, 16'h0);
    check("d6_oob_read6", db6, 16'h0);
    for (int i = 0; i < 6; i++) begin
      aa6 = 3'(i);
      #1;
      check($sformatf("d6_entry_%0d", i), da6, (i == 5) ? 16'h5555 : 16'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
